// File: rtl/nightrider_top.sv
// Knight Rider LED scanner for the ECP5-Mini board: bouncing head LED, button-selected speed, RGB speed indicator.
// Define NIGHTRIDER_FADE_TRAIL_EN to compile in the PWM fading trail behind the head.
module nightrider_top #(
  parameter int STEP_DIV        = 400000,
  parameter int DEBOUNCE_CYCLES = 16000
) (
  input  logic       clk_16mhz,
  input  logic       rst_n,
  input  logic       btn_usr,
  output logic       led_usr,
  output logic       led_act,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [7:0] led
);

  localparam int TMR_W = $clog2(STEP_DIV + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TMR_W-1:0] DIV0_M1 = TMR_W'(STEP_DIV - 1);
  localparam logic [TMR_W-1:0] DIV1_M1 = TMR_W'(STEP_DIV / 2 - 1);
  localparam logic [TMR_W-1:0] DIV2_M1 = TMR_W'(STEP_DIV / 4 - 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_p0, btn_p1;
  logic [DB_W-1:0]  db_cnt;
  logic             db_lvl, db_prev;
  logic             press;
  logic [1:0]       speed, speed_nxt;
  logic [2:0]       rgb;
  logic [TMR_W-1:0] tmr, div_m1;
  logic             step;
  logic [2:0]       pos, pos_nxt;
  logic             dir, dir_nxt;
  logic             act;

  // Stage p0/p1: two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn_usr;
      btn_p1 <= btn_p0;
    end
  end

  // Debounce: the level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt  <= '0;
      db_lvl  <= 1'b0;
      db_prev <= 1'b0;
    end else begin
      db_prev <= db_lvl;
      if (btn_p1 == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_lvl <= btn_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db_lvl & ~db_prev;

  always_comb begin
    speed_nxt = (speed == 2'd2) ? 2'd0 : speed + 2'd1;
    case (speed)
      2'd0:    div_m1 = DIV0_M1;
      2'd1:    div_m1 = DIV1_M1;
      default: div_m1 = DIV2_M1;
    endcase
  end

  // A press outranks a coincident step: the timer restarts under the new divider
  assign step = (tmr == div_m1) && !press;

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      speed <= 2'd0;
      rgb   <= 3'b100;
      tmr   <= '0;
    end else begin
      if (press) begin
        speed <= speed_nxt;
        rgb   <= {speed_nxt == 2'd0, speed_nxt == 2'd1, speed_nxt == 2'd2};
        tmr   <= '0;
      end else if (tmr == div_m1) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + 1'b1;
      end
    end
  end

  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (!dir) begin
      if (pos == 3'd7) begin
        dir_nxt = 1'b1;
        pos_nxt = 3'd6;
      end else begin
        pos_nxt = pos + 3'd1;
      end
    end else begin
      if (pos == 3'd0) begin
        dir_nxt = 1'b0;
        pos_nxt = 3'd1;
      end else begin
        pos_nxt = pos - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      pos <= 3'd0;
      dir <= 1'b0;
      act <= 1'b0;
    end else if (step) begin
      pos <= pos_nxt;
      dir <= dir_nxt;
      act <= ~act;
    end
  end

  assign led_usr = db_lvl;
  assign led_act = act;
  assign {led_r, led_g, led_b} = rgb;

`ifdef NIGHTRIDER_FADE_TRAIL_EN
  logic [3:0] level [8];
  logic [3:0] pwm_cnt;

  // Each step relights the new head and halves every other level, leaving a decaying trail
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 4'd0;
      for (int i = 0; i < 8; i++) level[i] <= (i == 0) ? 4'd15 : 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (step) begin
        for (int i = 0; i < 8; i++)
          level[i] <= (pos_nxt == 3'(i)) ? 4'd15 : {1'b0, level[i][3:1]};
      end
    end
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < 8; i++) led[i] = level[i] > pwm_cnt;
  end
`else
  assign led = 8'd1 << pos;
`endif

endmodule

// File: tb/tb_nightrider_top.sv
// Scoreboard bench for nightrider_top: stimulus queues the expected scan steps, a monitor checks each step as it appears.
module tb_nightrider_top;

  logic       clk_16mhz = 1'b0;
  logic       rst_n;
  logic       btn_usr;
  logic       led_usr, led_act, led_r, led_g, led_b;
  logic [7:0] led;

  nightrider_top #(.STEP_DIV(64), .DEBOUNCE_CYCLES(8)) dut (
    .clk_16mhz(clk_16mhz), .rst_n(rst_n), .btn_usr(btn_usr),
    .led_usr(led_usr), .led_act(led_act),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .led(led)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  typedef struct {
    logic [2:0] pos;
    int         gap;
    logic [2:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int p, input int gap, input logic [2:0] rgb);
    exp_t e;
    e.pos = 3'(p);
    e.gap = gap;
    e.rgb = rgb;
    sb.push_back(e);
  endtask

  // Edges since reset release; matches the DUT's free-running PWM phase
  always @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: a led_act toggle marks a step; gaps are measured from the last step or speed change
  logic       prev_act;
  logic [2:0] prev_rgb;
  int         ref_cyc;
  int         lvl [8];

  always @(negedge clk_16mhz) begin
    if (!rst_n) begin
      prev_act = 1'b0;
      prev_rgb = 3'b100;
      ref_cyc  = 0;
      for (int i = 0; i < 8; i++) lvl[i] = (i == 0) ? 15 : 0;
    end else begin
      if ({led_r, led_g, led_b} != prev_rgb) begin
        prev_rgb = {led_r, led_g, led_b};
        ref_cyc  = cyc;
      end
      if (led_act != prev_act) begin
        prev_act = led_act;
        if (sb.size() == 0) begin
          chk("unexpected_step", 1, 0);
        end else begin
          exp_t e;
          logic [7:0] exp_led;
          e = sb.pop_front();
          for (int i = 0; i < 8; i++) lvl[i] = (int'(e.pos) == i) ? 15 : lvl[i] / 2;
`ifdef NIGHTRIDER_FADE_TRAIL_EN
          for (int i = 0; i < 8; i++) exp_led[i] = lvl[i] > (cyc % 16);
`else
          exp_led = 8'd1 << e.pos;
`endif
          chk("step_led", int'(led), int'(exp_led));
          chk("step_gap", cyc - ref_cyc, e.gap);
          chk("step_rgb", int'({led_r, led_g, led_b}), int'(e.rgb));
        end
        ref_cyc = cyc;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 4000 && sb.size() > 0; i++) @(posedge clk_16mhz);
    #1;
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_size(input int n);
    for (int i = 0; i < 4000 && sb.size() > n; i++) @(posedge clk_16mhz);
    #1;
    chk("wait_timeout", sb.size(), n);
  endtask

  task automatic press_btn();
    int lat;
    lat = 99;
    @(posedge clk_16mhz); #1;
    btn_usr = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk_16mhz); #1;
      if (led_usr) begin
        lat = i;
        break;
      end
    end
    chk("usr_latency", lat, 10);
    repeat (10) @(posedge clk_16mhz);
    #1;
    btn_usr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_led"}, int'(led), 8'h01);
    chk({tag, "_rgb"}, int'({led_r, led_g, led_b}), 3'b100);
    chk({tag, "_act"}, int'(led_act), 0);
    chk({tag, "_usr"}, int'(led_usr), 0);
  endtask

  initial begin
    int c3, c0, usr_seen;
    int scan [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    rst_n   = 1'b0;
    btn_usr = 1'b0;
    repeat (3) @(posedge clk_16mhz);
    #1;
    check_reset_outputs("reset");

    foreach (scan[i]) push(scan[i], 64, 3'b100);
    @(negedge clk_16mhz);
    rst_n = 1'b1;

    // Trail shape once the head has reached pos 3
    wait_size(12);
    c3 = 0;
    c0 = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_16mhz); #1;
      c3 += int'(led[3]);
      c0 += int'(led[0]);
    end
`ifdef NIGHTRIDER_FADE_TRAIL_EN
    chk("fade_led3_duty", c3, 15);
    chk("fade_led0_duty", c0, 1);
`else
    chk("head_led3_duty", c3, 16);
    chk("head_led0_duty", c0, 0);
`endif
    drain();

    // Short glitch must not register
    btn_usr = 1'b1;
    repeat (5) @(posedge clk_16mhz);
    #1;
    btn_usr = 1'b0;
    usr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_16mhz); #1;
      usr_seen |= int'(led_usr);
    end
    chk("glitch_usr", usr_seen, 0);
    push(2, 64, 3'b100);
    push(3, 64, 3'b100);
    drain();

    press_btn();
    push(4, 32, 3'b010); push(5, 32, 3'b010); push(6, 32, 3'b010); push(7, 32, 3'b010);
    drain();
    press_btn();
    push(6, 16, 3'b001); push(5, 16, 3'b001); push(4, 16, 3'b001); push(3, 16, 3'b001);
    drain();
    press_btn();
    push(2, 64, 3'b100); push(1, 64, 3'b100); push(0, 64, 3'b100); push(1, 64, 3'b100);
    drain();

    press_btn();
    push(2, 32, 3'b010); push(3, 32, 3'b010);
    drain();
    press_btn();
    push(4, 16, 3'b001); push(5, 16, 3'b001);
    drain();

    // Asynchronous reset between clock edges at speed 2
    repeat (3) @(posedge clk_16mhz);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (2) @(negedge clk_16mhz);
    push(1, 64, 3'b100);
    push(2, 64, 3'b100);
    rst_n = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
